// File: rtl/rng_pkg.sv
// Shared types and IEEE-754 field constants for the RNG front-end scheduler.
package rng_pkg;

   typedef enum logic {S_U1 = 1'b0, S_U2 = 1'b1} state_t;

   localparam logic [10:0] EXP_MAX_VALID = 11'd1022;
   localparam int          SIGN_BIT      = 63;
   localparam int          EXP_HI        = 62;
   localparam int          EXP_LO        = 52;

   typedef struct packed {
      logic [63:0] u1;
      logic [63:0] u2;
   } pair_t;

   // Any non-negative double with biased exponent <= 1022 is strictly below 1.0.
   function automatic logic in_unit_interval(input logic [63:0] d);
      return !d[SIGN_BIT] && (d[EXP_HI:EXP_LO] <= EXP_MAX_VALID);
   endfunction

endpackage

// File: rtl/rand_pair_sched_if.sv
// RNG input stream and pair output stream of the scheduler.
interface rand_pair_sched_if #(parameter int SEQW = 8);
   logic            pushin;
   logic [63:0]     rand_in;
   logic            stopout;
   logic            pushout;
   logic            stopin;
   logic [63:0]     u1;
   logic [63:0]     u2;
   logic [SEQW-1:0] seq;
   logic [15:0]     rej_cnt;

   modport slave  (input  pushin, rand_in, stopin,
                   output stopout, pushout, u1, u2, seq, rej_cnt);
   modport master (output pushin, rand_in, stopin,
                   input  stopout, pushout, u1, u2, seq, rej_cnt);
endinterface

// File: rtl/rand_pair_sched_pair_fifo.sv
// Synchronous pair FIFO; head entry reads as zero while empty.
module pair_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 136
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         // push and pop together leave the occupancy unchanged
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/rand_pair_sched.sv
// Filters RNG doubles to [0,1), pairs consecutive survivors into (u1,u2) and queues them.
module rand_pair_sched
   import rng_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SEQW  = 8
) (
   input  logic            clk,
   input  logic            reset,
   rand_pair_sched_if.slave bus
);
   localparam int W = 128 + SEQW;

   state_t                state, state_nxt;
   logic [63:0]           u1_hold;
   logic [SEQW-1:0]       seq_next;
   logic [15:0]           rej_cnt_q;
   logic                  accept, valid, push, pop;
   logic                  full, empty;
   logic [$clog2(DEPTH):0] count;
   logic [W-1:0]          head;
   pair_t                 head_pair;

   // Only a second value waiting on a full FIFO stalls; no same-cycle pass-through.
   assign bus.stopout = (state == S_U2) && full;
   assign accept      = bus.pushin && !bus.stopout;
   assign valid       = in_unit_interval(bus.rand_in);
   assign push        = accept && valid && (state == S_U2);
   assign pop         = bus.pushout && !bus.stopin;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_U1;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (accept && valid) begin
         unique case (state)
            S_U1:    state_nxt = S_U2;
            S_U2:    state_nxt = S_U1;
            default: state_nxt = S_U1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         u1_hold   <= '0;
         seq_next  <= '0;
         rej_cnt_q <= '0;
      end else begin
         if (accept && valid && state == S_U1) u1_hold <= bus.rand_in;
         if (push) seq_next <= seq_next + 1'b1;
         if (accept && !valid && rej_cnt_q != 16'hFFFF) rej_cnt_q <= rej_cnt_q + 16'd1;
      end
   end

   pair_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   ({u1_hold, bus.rand_in, seq_next}),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign head_pair   = head[W-1:SEQW];
   assign bus.pushout = !empty;
   assign bus.u1      = head_pair.u1;
   assign bus.u2      = head_pair.u2;
   assign bus.seq     = head[SEQW-1:0];
   assign bus.rej_cnt = rej_cnt_q;
endmodule

// File: tb/tb_rand_pair_sched.sv
// Directed bench for rand_pair_sched with a pair-order scoreboard monitor.
module tb_rand_pair_sched;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   rand_pair_sched_if #(.SEQW(8)) bus ();
   rand_pair_sched #(.DEPTH(4), .SEQW(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [63:0] u1;
      logic [63:0] u2;
      logic [7:0]  seq;
   } exp_t;

   exp_t        exp_q[$];
   logic        m_state;
   logic [63:0] m_hold;
   logic [7:0]  m_seq;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   // Offer one value, hold it until accepted, then update the reference model.
   task automatic send(input logic [63:0] v);
      int tries = 0;
      exp_t e;
      @(negedge clk);
      bus.pushin  = 1'b1;
      bus.rand_in = v;
      #1;
      while (bus.stopout && tries < 100) begin
         @(negedge clk);
         #1;
         tries++;
      end
      if (bus.stopout) begin
         n_cmp++;
         n_err++;
         $error("FAIL send_timeout: got stopout=1 want 0 for %h", v);
         bus.pushin = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.pushin = 1'b0;
      if (!v[63] && v[62:52] <= 11'd1022) begin
         if (!m_state) begin
            m_hold  = v;
            m_state = 1'b1;
         end else begin
            e.u1 = m_hold; e.u2 = v; e.seq = m_seq;
            exp_q.push_back(e);
            m_seq   = m_seq + 8'd1;
            m_state = 1'b0;
         end
      end
   endtask

   task automatic rst_dut();
      @(negedge clk);
      bus.pushin = 1'b0;
      reset      = 1'b1;
      exp_q.delete();
      m_state = 1'b0;
      m_seq   = 8'd0;
      #1;
      chk("rst_pushout", 64'(bus.pushout), 64'd0);
      chk("rst_stopout", 64'(bus.stopout), 64'd0);
      chk("rst_u1", bus.u1, 64'd0);
      chk("rst_u2", bus.u2, 64'd0);
      chk("rst_seq", 64'(bus.seq), 64'd0);
      chk("rst_rej", 64'(bus.rej_cnt), 64'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard: pushout tracks model occupancy, head matches in order, zero when empty.
   always @(negedge clk) begin
      #2;
      if (!reset) begin
         chk("mon_pushout", 64'(bus.pushout), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("mon_u1", bus.u1, exp_q[0].u1);
            chk("mon_u2", bus.u2, exp_q[0].u2);
            chk("mon_seq", 64'(bus.seq), 64'(exp_q[0].seq));
            if (!bus.stopin) void'(exp_q.pop_front());
         end else begin
            chk("mon_empty_u1", bus.u1, 64'd0);
            chk("mon_empty_seq", 64'(bus.seq), 64'd0);
         end
      end
   end

   initial begin
      bus.pushin  = 1'b0;
      bus.rand_in = 64'd0;
      bus.stopin  = 1'b0;
      m_state = 1'b0;
      m_hold  = 64'd0;
      m_seq   = 8'd0;

      // reset state
      rst_dut();

      // basic pairing
      send(64'h3FE0000000000000);
      send(64'h3FD0000000000000);
      @(negedge clk); #1;
      chk("p0_pushout", 64'(bus.pushout), 64'd1);
      chk("p0_u1", bus.u1, 64'h3FE0000000000000);
      chk("p0_u2", bus.u2, 64'h3FD0000000000000);
      chk("p0_seq", 64'(bus.seq), 64'd0);
      send(64'h3FC0000000000000);
      send(64'h3FB0000000000000);
      @(negedge clk); #1;
      chk("p1_seq", 64'(bus.seq), 64'd1);
      chk("p1_u1", bus.u1, 64'h3FC0000000000000);

      // rejects: 1.0 and -0.5 leave state in S_U1
      send(64'h3FF0000000000000);
      send(64'hBFE0000000000000);
      @(negedge clk); #1;
      chk("rej_pushout", 64'(bus.pushout), 64'd0);
      chk("rej_cnt2", 64'(bus.rej_cnt), 64'd2);
      send(64'h3FA0000000000000);
      send(64'h3F90000000000000);
      @(negedge clk); #1;
      chk("rej_pair_u1", bus.u1, 64'h3FA0000000000000);
      chk("rej_pair_u2", bus.u2, 64'h3F90000000000000);
      chk("rej_pair_seq", 64'(bus.seq), 64'd2);

      // back-pressure with full FIFO
      rst_dut();
      @(negedge clk); bus.stopin = 1'b1;
      for (int i = 0; i < 9; i++) send({1'b0, 11'd1010, 52'(i + 1)});
      @(negedge clk); #1;
      chk("full_stopout", 64'(bus.stopout), 64'd1);
      chk("full_pushout", 64'(bus.pushout), 64'd1);
      chk("full_head_seq", 64'(bus.seq), 64'd0);
      bus.stopin = 1'b0;
      send({1'b0, 11'd1010, 52'd10});
      wait_cycles(8);
      #1;
      chk("drain_pushout", 64'(bus.pushout), 64'd0);
      chk("drain_stopout", 64'(bus.stopout), 64'd0);

      // reset mid-pair discards held u1
      send(64'h3FE0000000000000);
      rst_dut();
      send(64'h3FC0000000000000);
      send(64'h3FB0000000000000);
      @(negedge clk); #1;
      chk("midrst_u1", bus.u1, 64'h3FC0000000000000);
      chk("midrst_u2", bus.u2, 64'h3FB0000000000000);
      chk("midrst_seq", 64'(bus.seq), 64'd0);

      // seq wrap after 256 pairs
      rst_dut();
      for (int i = 0; i < 257; i++) begin
         send({1'b0, 11'd1000, 52'(2 * i)});
         send({1'b0, 11'd1000, 52'(2 * i + 1)});
      end
      @(negedge clk); #1;
      chk("wrap_seq", 64'(bus.seq), 64'd0);
      chk("wrap_u2", bus.u2, {1'b0, 11'd1000, 52'd513});
      chk("wrap_rej", 64'(bus.rej_cnt), 64'd0);
      wait_cycles(4);
      chk("final_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
